// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU command sequencer
package alu_seq_pkg;

    localparam int W      = 8;
    localparam int SELW   = 3;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2
    } state_e;

    typedef struct packed {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [SELW-1:0] sel;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and result signals of the sequencer
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [SELW-1:0] in_sel;

    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [SELW-1:0] alu_sel;
    logic [W-1:0]    alu_res;
    logic            alu_c;

    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_res;
    logic            out_c;
    logic [SELW-1:0] out_sel;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_res, alu_c, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_res, out_c, out_sel
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, alu_res, alu_c, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_res, out_c, out_sel
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - DEPTH-entry command FIFO; pointers wrap modulo DEPTH
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - feeds queued commands to a combinational ALU, registers results
// ALU_SEQ_STATS_EN adds saturating capture/carry counters on stat_ops_o/stat_carry_o.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ALU_SEQ_STATS_EN
    output logic [STAT_W-1:0]   stat_ops_o,
    output logic [STAT_W-1:0]   stat_carry_o,
`endif
    alu_cmd_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_EVAL = ST_EVAL;

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    alu_a_q, alu_b_q;
    logic [SELW-1:0] alu_sel_q;
    logic            out_valid_q;
    logic [W-1:0]    out_res_q;
    logic            out_c_q;
    logic [SELW-1:0] out_sel_q;

    cmd_t fifo_din, fifo_head;
    logic fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic capture;

    assign fifo_din  = '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel};
    assign fifo_push = bus.in_valid && bus.in_ready;
    assign fifo_pop  = (state_q == S_LOAD);

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The output slot is free if empty or being drained this very cycle.
    assign capture = (state_q == S_EVAL) && (!out_valid_q || bus.out_ready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!fifo_empty) state_d = S_LOAD;
            S_LOAD:  state_d = S_EVAL;
            S_EVAL:  if (capture) state_d = fifo_empty ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_c_q     <= 1'b0;
            out_sel_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_LOAD) begin
                alu_a_q   <= fifo_head.a;
                alu_b_q   <= fifo_head.b;
                alu_sel_q <= fifo_head.sel;
            end
            if (capture) begin
                out_res_q   <= bus.alu_res;
                out_c_q     <= bus.alu_c;
                out_sel_q   <= alu_sel_q;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [STAT_W-1:0] stat_ops_q, stat_carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q   <= '0;
            stat_carry_q <= '0;
        end else if (capture) begin
            if (stat_ops_q != '1) begin
                stat_ops_q <= stat_ops_q + STAT_W'(1);
            end
            if (bus.alu_c && (stat_carry_q != '1)) begin
                stat_carry_q <= stat_carry_q + STAT_W'(1);
            end
        end
    end

    assign stat_ops_o   = stat_ops_q;
    assign stat_carry_o = stat_carry_q;
`endif

    assign bus.in_ready  = !fifo_full && !rst;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with an adder ALU stub
module tb_alu_cmd_sequencer;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic [2:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    int   hs_cyc[$];

    alu_cmd_sequencer_if bus ();

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_carry;
`endif

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ALU_SEQ_STATS_EN
        .stat_ops_o   (stat_ops),
        .stat_carry_o (stat_carry),
`endif
        .bus          (bus)
    );

    assign {bus.alu_c, bus.alu_res} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] p_res;
    logic       p_c;
    logic [2:0] p_sel;

    always @(negedge clk) begin
        logic [8:0] sum;
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!bus.out_valid || bus.out_res !== p_res || bus.out_c !== p_c || bus.out_sel !== p_sel) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b res=%0d c=%0b sel=%0d want v=1 res=%0d c=%0b sel=%0d",
                             bus.out_valid, bus.out_res, bus.out_c, bus.out_sel, p_res, p_c, p_sel);
                end
            end
            if (bus.out_valid && (!prev_valid || prev_hs)) begin
                sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                total++;
                if ({bus.out_c, bus.out_res} !== sum || bus.out_sel !== bus.alu_sel) begin
                    bad++;
                    $display("FAIL alu_hold: got c=%0b res=%0d sel=%0d want c=%0b res=%0d sel=%0d",
                             bus.out_c, bus.out_res, bus.out_sel, sum[8], sum[7:0], bus.alu_sel);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got res=%0d c=%0b sel=%0d want none",
                             bus.out_res, bus.out_c, bus.out_sel);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_res !== e.res || bus.out_c !== e.c || bus.out_sel !== e.sel) begin
                        bad++;
                        $display("FAIL result_order: got res=%0d c=%0b sel=%0d want res=%0d c=%0b sel=%0d",
                                 bus.out_res, bus.out_c, bus.out_sel, e.res, e.c, e.sel);
                    end
                end
                hs_cyc.push_back(cyc);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_valid = bus.out_valid;
            p_res      = bus.out_res;
            p_c        = bus.out_c;
            p_sel      = bus.out_sel;
        end
    end

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return '{res: sum[7:0], c: sum[8], sel: s};
    endfunction

    // Leaves in_valid high so consecutive calls form a back-to-back stream.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = s;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (acc) begin
            exp_q.push_back(model(a, b, s));
        end else begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want accept a=%0d b=%0d", a, b);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        total++;
        if (k == budget) begin
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_res !== 8'd0 || bus.out_c !== 1'b0 || bus.out_sel !== 3'd0) begin
            bad++;
            $display("FAIL reset_out: got v=%0b res=%0d c=%0b sel=%0d want all 0",
                     bus.out_valid, bus.out_res, bus.out_c, bus.out_sel);
        end
        total++;
        if (bus.alu_a !== 8'd0 || bus.alu_b !== 8'd0 || bus.alu_sel !== 3'd0) begin
            bad++;
            $display("FAIL reset_alu: got a=%0d b=%0d sel=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %0b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        bus.out_ready = 1'b1;
        send(8'd200, 8'd100, 3'd0);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== (k == 3)) begin
                bad++;
                $display("FAIL latency_edge%0d: got out_valid=%0b want %0b", k, bus.out_valid, (k == 3));
            end
        end
        total++;
        if (bus.out_res !== 8'd44 || bus.out_c !== 1'b1 || bus.out_sel !== 3'd0) begin
            bad++;
            $display("FAIL latency_value: got res=%0d c=%0b sel=%0d want res=44 c=1 sel=0",
                     bus.out_res, bus.out_c, bus.out_sel);
        end
        wait_drain(20);
    endtask

    task automatic test_backpressure();
        logic acc;
        int   n0;
        bus.out_ready = 1'b0;
        send(8'd10, 8'd20, 3'd1);
        send(8'd255, 8'd1, 3'd2);
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(i * 37 + 5);
            bus.in_b     = 8'(i * 71 + 150);
            bus.in_sel   = 3'(i + 3);
            @(negedge clk);
            acc = bus.in_ready;
            total++;
            if (acc !== (i < 4)) begin
                bad++;
                $display("FAIL full_ready_cmd%0d: got in_ready=%0b want %0b", i, acc, (i < 4));
            end
            @(posedge clk);
            #1;
            if (acc) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_sel));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_hold: got in_ready=%0b out_valid=%0b want 0/1", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        n0 = hs_cyc.size();
        bus.out_ready = 1'b1;
        send(8'(4 * 37 + 5), 8'(4 * 71 + 150), 3'(7));
        bus.in_valid = 1'b0;
        wait_drain(60);
        total++;
        if (hs_cyc.size() - n0 !== 7) begin
            bad++;
            $display("FAIL backpressure_count: got %0d want 7", hs_cyc.size() - n0);
        end
    endtask

    task automatic test_stream();
        int gap_bad;
        bus.out_ready = 1'b1;
        hs_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(i));
        end
        bus.in_valid = 1'b0;
        wait_drain(60);
        total++;
        if (hs_cyc.size() !== 10) begin
            bad++;
            $display("FAIL stream_count: got %0d want 10", hs_cyc.size());
        end
        gap_bad = 0;
        for (int i = 1; i < hs_cyc.size(); i++) begin
            if (hs_cyc[i] - hs_cyc[i-1] != 2) gap_bad++;
        end
        total++;
        if (gap_bad !== 0) begin
            bad++;
            $display("FAIL stream_rate: got %0d gaps not equal to 2 want 0", gap_bad);
        end
    endtask

    task automatic test_toggle();
        int n0;
        n0 = hs_cyc.size();
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ~bus.out_ready;
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain(60);
        total++;
        if (hs_cyc.size() - n0 !== 6) begin
            bad++;
            $display("FAIL toggle_count: got %0d want 6", hs_cyc.size() - n0);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.out_ready = 1'b0;
        send(8'd1, 8'd2, 3'd1);
        send(8'd3, 8'd4, 3'd2);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(8'd5, 8'd6, 3'd3);
        send(8'd7, 8'd8, 3'd4);
        send(8'd9, 8'd10, 3'd5);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_in_ready: got %0b want 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_state: got out_valid=%0b in_ready=%0b want 0/1", bus.out_valid, bus.in_ready);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_stale: got %0d valid cycles want 0", seen);
        end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        do_reset();
        bus.out_ready = 1'b1;
        send(8'd200, 8'd100, 3'd0);
        send(8'd1, 8'd2, 3'd1);
        send(8'd3, 8'd4, 3'd2);
        bus.in_valid = 1'b0;
        wait_drain(40);
        @(negedge clk);
        total++;
        if (stat_ops !== 16'd3 || stat_carry !== 16'd1) begin
            bad++;
            $display("FAIL stats: got ops=%0d carry=%0d want 3/1", stat_ops, stat_carry);
        end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_stream();
        test_toggle();
        test_reset_mid();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
